// File: rtl/star_pkg.sv
// Shared sizes, background colour, FSM encoding and raster helpers for the
// star frame scanner and its raster counter.
package star_pkg;
  localparam int xSz     = 8;
  localparam int ySz     = 7;
  localparam int colSz   = 3;
  localparam int X_MAX   = 160;
  localparam int Y_MAX   = 120;
  localparam int ADDR_SZ = 15;

  localparam logic [colSz-1:0] BG_COL = 3'b000;
  localparam logic [xSz-1:0]   X_LAST = xSz'(X_MAX - 1);
  localparam logic [ySz-1:0]   Y_LAST = ySz'(Y_MAX - 1);

  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t SCAN  = 2'd1;
  localparam state_t FOUND = 2'd2;
  localparam state_t DONE  = 2'd3;

  typedef struct packed {
    logic [xSz-1:0] x;
    logic [ySz-1:0] y;
  } pix_t;

  // Next pixel in raster order; the last pixel of the frame saturates.
  function automatic pix_t pix_next(input pix_t p);
    pix_t n;
    n = p;
    if (p.x != X_LAST) begin
      n.x = p.x + 1'b1;
    end else if (p.y != Y_LAST) begin
      n.x = '0;
      n.y = p.y + 1'b1;
    end
    return n;
  endfunction

  // y*160 + x built from two shifts, no multiplier.
  function automatic logic [ADDR_SZ-1:0] pix_addr(input pix_t p);
    return (ADDR_SZ'(p.y) << 7) + (ADDR_SZ'(p.y) << 5) + ADDR_SZ'(p.x);
  endfunction
endpackage

// File: rtl/raster_counter.sv
// Raster x/y read counter: clear, advance with wrap, or reload to the pixel
// after a given (x,y); also produces the linear memory address.
module raster_counter
  import star_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  input  logic               i_clr,
  input  logic               i_adv,
  input  logic               i_load,
  input  logic [xSz-1:0]     i_ld_x,
  input  logic [ySz-1:0]     i_ld_y,
  output logic [xSz-1:0]     o_x,
  output logic [ySz-1:0]     o_y,
  output logic [ADDR_SZ-1:0] o_addr,
  output logic               o_last
);
  pix_t r_pix;
  pix_t w_ld_pix;

  assign w_ld_pix = {i_ld_x, i_ld_y};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pix <= '0;
    end else if (i_clr) begin
      r_pix <= '0;
    end else if (i_load) begin
      r_pix <= pix_next(w_ld_pix);
    end else if (i_adv) begin
      r_pix <= pix_next(r_pix);
    end
  end

  assign o_x    = r_pix.x;
  assign o_y    = r_pix.y;
  assign o_addr = pix_addr(r_pix);
  assign o_last = (r_pix.x == X_LAST) && (r_pix.y == Y_LAST);
endmodule

// File: rtl/frame_scanner.sv
// Raster reader for the 160x120 star frame: stops on the first non-background
// pixel, reports its coordinates, and can resume from the following pixel.
module frame_scanner
  import star_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               resume,
  output logic [ADDR_SZ-1:0] mem_addr,
  output logic               mem_rd_en,
  input  logic [colSz-1:0]   mem_data,
  output logic [xSz-1:0]     xCount,
  output logic [ySz-1:0]     yCount,
  output logic               starFound,
  output logic               scanDone
);
  state_t             r_state;
  state_t             w_state_next;
  logic               r_rd_done;
  logic               r_pend_v;
  logic [xSz-1:0]     r_pend_x;
  logic [ySz-1:0]     r_pend_y;
  logic [xSz-1:0]     r_x_hit;
  logic [ySz-1:0]     r_y_hit;
  logic [xSz-1:0]     w_cnt_x;
  logic [ySz-1:0]     w_cnt_y;
  logic [ADDR_SZ-1:0] w_cnt_addr;
  logic               w_cnt_last;
  logic               w_rd_en;
  logic               w_hit;
  logic               w_scan_go;
  logic               w_pend_last;
  logic               w_hit_last;

  assign w_scan_go   = (r_state == IDLE) && start;
  assign w_rd_en     = (r_state == SCAN) && !r_rd_done;
  assign w_hit       = (r_state == SCAN) && r_pend_v && (mem_data != BG_COL);
  assign w_pend_last = (r_pend_x == X_LAST) && (r_pend_y == Y_LAST);
  assign w_hit_last  = (r_x_hit == X_LAST) && (r_y_hit == Y_LAST);

  // A hit rewinds the counter past the speculative read issued alongside it.
  raster_counter u_raster_counter (
    .clk    (clk),
    .resetn (resetn),
    .i_clr  (w_scan_go),
    .i_adv  (w_rd_en),
    .i_load (w_hit),
    .i_ld_x (r_pend_x),
    .i_ld_y (r_pend_y),
    .o_x    (w_cnt_x),
    .o_y    (w_cnt_y),
    .o_addr (w_cnt_addr),
    .o_last (w_cnt_last)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = SCAN;
      SCAN: begin
        if (w_hit) begin
          w_state_next = FOUND;
        end else if (r_rd_done) begin
          w_state_next = DONE;
        end
      end
      FOUND: begin
        if (!start) begin
          w_state_next = IDLE;
        end else if (resume) begin
          w_state_next = w_hit_last ? DONE : SCAN;
        end
      end
      DONE:    if (!start) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_addr  = '0;
    mem_rd_en = 1'b0;
    xCount    = '0;
    yCount    = '0;
    starFound = 1'b0;
    scanDone  = 1'b0;
    case (r_state)
      SCAN: begin
        mem_rd_en = w_rd_en;
        mem_addr  = w_rd_en ? w_cnt_addr : '0;
        xCount    = r_x_hit;
        yCount    = r_y_hit;
      end
      FOUND: begin
        starFound = 1'b1;
        xCount    = r_x_hit;
        yCount    = r_y_hit;
      end
      DONE: begin
        scanDone = 1'b1;
        xCount   = r_x_hit;
        yCount   = r_y_hit;
      end
      default: ;
    endcase
  end

  // Compare pipeline and hit capture; r_rd_done marks the last address issued.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rd_done <= 1'b0;
      r_pend_v  <= 1'b0;
      r_pend_x  <= '0;
      r_pend_y  <= '0;
      r_x_hit   <= '0;
      r_y_hit   <= '0;
    end else begin
      r_pend_v <= w_rd_en && !w_hit;
      if (w_rd_en) begin
        r_pend_x <= w_cnt_x;
        r_pend_y <= w_cnt_y;
      end
      if (w_scan_go) begin
        r_rd_done <= 1'b0;
        r_x_hit   <= '0;
        r_y_hit   <= '0;
      end else if (w_hit) begin
        r_rd_done <= w_pend_last;
        r_x_hit   <= r_pend_x;
        r_y_hit   <= r_pend_y;
      end else if (w_rd_en && w_cnt_last) begin
        r_rd_done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_frame_scanner.sv
// Scoreboard bench for frame_scanner: expected hit/done events are queued when
// a scan or resume is driven and checked when the DUT raises starFound/scanDone.
module tb_frame_scanner;
  import star_pkg::*;

  logic               clk = 1'b0;
  logic               resetn;
  logic               start;
  logic               resume;
  logic [ADDR_SZ-1:0] mem_addr;
  logic               mem_rd_en;
  logic [colSz-1:0]   mem_data = '0;
  logic [xSz-1:0]     xCount;
  logic [ySz-1:0]     yCount;
  logic               starFound;
  logic               scanDone;

  frame_scanner dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .resume    (resume),
    .mem_addr  (mem_addr),
    .mem_rd_en (mem_rd_en),
    .mem_data  (mem_data),
    .xCount    (xCount),
    .yCount    (yCount),
    .starFound (starFound),
    .scanDone  (scanDone)
  );

  always #5 clk = ~clk;

  logic [colSz-1:0] mem [0:X_MAX*Y_MAX-1];
  always @(posedge clk) if (mem_rd_en) mem_data <= mem[mem_addr];

  typedef struct {
    int kind;   // 1 = starFound rise, 2 = scanDone rise
    int x;
    int y;
    int cyc;    // cycle relative to t0
  } ev_t;
  ev_t sb_q[$];

  int cyc = 0;
  int t0 = 0;
  int n_cmp = 0;
  int n_err = 0;
  int n_reads = 0;
  int first_addr = -1;
  int first_cyc = -1;
  logic prev_found = 1'b0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic on_event(input int kind);
    ev_t e;
    if (sb_q.size() == 0) begin
      check("unexpected_event", kind, 0);
    end else begin
      e = sb_q.pop_front();
      check("ev_kind", kind, e.kind);
      check("ev_cycle", cyc - t0, e.cyc);
      check("ev_x", int'(xCount), e.x);
      check("ev_y", int'(yCount), e.y);
    end
  endtask

  always @(negedge clk) begin
    if (resetn) begin
      if (mem_rd_en) begin
        n_reads = n_reads + 1;
        if (cyc == t0) begin
          first_addr = int'(mem_addr);
          first_cyc  = cyc;
        end
      end
      if (starFound && !prev_found) on_event(1);
      if (scanDone && !prev_done) on_event(2);
    end
    prev_found = starFound;
    prev_done  = scanDone;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < X_MAX*Y_MAX; i++) mem[i] = BG_COL;
  endtask

  task automatic push_ev(input int kind, input int x, input int y, input int c);
    ev_t e;
    e.kind = kind; e.x = x; e.y = y; e.cyc = c;
    sb_q.push_back(e);
  endtask

  task automatic raise_start();
    step();
    start = 1'b1;
    t0 = cyc + 1;
  endtask

  task automatic pulse_resume();
    step();
    resume = 1'b1;
    t0 = cyc + 1;
    step();
    resume = 1'b0;
  endtask

  task automatic wait_sb(input int budget);
    for (int i = 0; i < budget && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      check("sb_timeout_pending", sb_q.size(), 0);
      sb_q.delete();
    end
  endtask

  task automatic check_first(input string tag, input int exp);
    check(tag, (first_cyc == t0) ? first_addr : -1, exp);
  endtask

  int base;

  initial begin
    resetn = 1'b0;
    start  = 1'b0;
    resume = 1'b0;
    clear_mem();
    repeat (3) step();
    check("rst_rd_en", int'(mem_rd_en), 0);
    check("rst_addr", int'(mem_addr), 0);
    check("rst_found", int'(starFound), 0);
    check("rst_done", int'(scanDone), 0);
    check("rst_x", int'(xCount), 0);
    check("rst_y", int'(yCount), 0);
    resetn = 1'b1;
    step();

    // Single star at (37,52) = address 8357
    mem[8357] = 3'd5;
    push_ev(1, 37, 52, 8359);
    base = n_reads;
    raise_start();
    wait_sb(9000);
    check_first("s1_first_addr", 0);
    check("s1_reads", n_reads - base, 8359);
    repeat (4) @(negedge clk);
    check("s1_reads_after_hit", n_reads - base, 8359);
    check("s1_rd_en_in_found", int'(mem_rd_en), 0);
    check("s1_found_held", int'(starFound), 1);
    step();
    start = 1'b0;
    step();
    @(negedge clk);
    check("s1_idle_found", int'(starFound), 0);
    check("s1_idle_x", int'(xCount), 0);

    // Blank frame, then start held in DONE, then a fresh scan
    clear_mem();
    push_ev(2, 0, 0, 19201);
    base = n_reads;
    raise_start();
    wait_sb(19300);
    check("s2_reads", n_reads - base, 19200);
    base = n_reads;
    repeat (100) @(negedge clk);
    check("s2_hold_reads", n_reads - base, 0);
    check("s2_hold_done", int'(scanDone), 1);
    mem[20] = 3'd1;
    push_ev(1, 20, 0, 22);
    step();
    start = 1'b0;
    raise_start();
    wait_sb(100);
    check_first("s2_rescan_first_addr", 0);
    step();
    start = 1'b0;
    step();

    // Stars at the first and last pixels
    clear_mem();
    mem[0]     = 3'd2;
    mem[19199] = 3'd7;
    push_ev(1, 0, 0, 2);
    raise_start();
    wait_sb(50);
    check_first("s3_first_addr", 0);
    push_ev(1, 159, 119, 19200);
    pulse_resume();
    wait_sb(19300);
    check_first("s3_resume_addr", 1);
    push_ev(2, 159, 119, 0);
    base = n_reads;
    pulse_resume();
    wait_sb(10);
    repeat (3) @(negedge clk);
    check("s3_no_reads_to_done", n_reads - base, 0);
    step();
    start = 1'b0;
    step();

    // Reset mid-scan, then restart from address 0
    clear_mem();
    raise_start();
    repeat (5000) @(posedge clk);
    #3;
    check("s4_scanning", int'(mem_rd_en), 1);
    resetn = 1'b0;
    #1;
    check("s4_rst_rd_en", int'(mem_rd_en), 0);
    check("s4_rst_addr", int'(mem_addr), 0);
    check("s4_rst_found", int'(starFound), 0);
    check("s4_rst_done", int'(scanDone), 0);
    repeat (2) step();
    mem[10] = 3'd3;
    push_ev(1, 10, 0, 12);
    resetn = 1'b1;
    t0 = cyc + 1;
    wait_sb(50);
    check_first("s4_restart_addr", 0);

    // start=0 together with resume in FOUND: back to IDLE, no reads
    step();
    start  = 1'b0;
    resume = 1'b1;
    step();
    resume = 1'b0;
    base = n_reads;
    @(negedge clk);
    check("s5_found_cleared", int'(starFound), 0);
    repeat (3) @(negedge clk);
    check("s5_no_reads", n_reads - base, 0);
    check("s5_rd_en", int'(mem_rd_en), 0);
    check("s5_done", int'(scanDone), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
